// File: rtl/ni_spike_tx.sv
// Network-interface spike transmitter: packs a spike vector into head/body/tail flits under per-VC credit flow control.
// Optional NI_TX_EMPTY_DROP_EN: an accepted all-zero spike vector is discarded instead of being sent.
module ni_spike_tx #(
    parameter int unsigned VIRTUAL_CHANNEL = 4,
    parameter int unsigned ADDRESS_WIDTH   = 5,
    parameter int unsigned FLIT_WIDTH      = 38,
    parameter int unsigned NUM_NURNS       = 128,
    parameter int unsigned BUFFER_DEPTH    = 8
) (
    input  logic                       router_clk,
    input  logic                       router_rst,
    input  logic                       spike_valid,
    input  logic [NUM_NURNS-1:0]       spike_in,
    input  logic [ADDRESS_WIDTH-1:0]   src_x,
    input  logic [ADDRESS_WIDTH-1:0]   src_y,
    input  logic [ADDRESS_WIDTH-1:0]   dest_x,
    input  logic [ADDRESS_WIDTH-1:0]   dest_y,
    output logic                       spike_ready,
    input  logic [VIRTUAL_CHANNEL-1:0] credit_in,
    output logic                       flit_out_wr,
    output logic [FLIT_WIDTH-1:0]      flit_out,
    output logic                       busy
);
    localparam int unsigned PAYLOAD_FLITS = NUM_NURNS / 32;
    localparam int unsigned IDX_W         = $clog2(PAYLOAD_FLITS + 1);
    localparam int unsigned CNT_W         = $clog2(BUFFER_DEPTH) + 1;
    localparam int unsigned VC_W          = (VIRTUAL_CHANNEL > 1) ? $clog2(VIRTUAL_CHANNEL) : 1;
    localparam logic [1:0]  TYPE_HEAD     = 2'b10;
    localparam logic [1:0]  TYPE_BODY     = 2'b00;
    localparam logic [1:0]  TYPE_TAIL     = 2'b01;

    typedef enum logic [1:0] {IDLE = 2'd0, ALLOC = 2'd1, SEND = 2'd2} state_t;
    state_t state, state_next;

    logic [NUM_NURNS-1:0]       spikes;
    logic [ADDRESS_WIDTH-1:0]   dx_q, dy_q;
    logic [VC_W-1:0]            vc_q, vc_sel;
    logic                       vc_found;
    logic [IDX_W-1:0]           idx;
    logic [CNT_W-1:0]           credit_cnt [VIRTUAL_CHANNEL];
    logic                       load, issue, last;
    logic [VIRTUAL_CHANNEL-1:0] vc_onehot, issue_vc;
    logic [1:0]                 flit_type;
    logic [31:0]                flit_data;
    logic [FLIT_WIDTH-1:0]      flit_next;

`ifdef NI_TX_EMPTY_DROP_EN
    assign load = spike_valid & spike_ready & (|spike_in);
`else
    assign load = spike_valid & spike_ready;
`endif

    assign last = (idx == IDX_W'(PAYLOAD_FLITS));

    // Lowest-index VC that still has downstream space
    always_comb begin
        vc_found = 1'b0;
        vc_sel   = '0;
        for (int v = int'(VIRTUAL_CHANNEL) - 1; v >= 0; v--) begin
            if (credit_cnt[v] != '0) begin
                vc_found = 1'b1;
                vc_sel   = VC_W'(v);
            end
        end
    end

    always_ff @(posedge router_clk) begin
        if (router_rst) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = ALLOC;
            ALLOC:   if (vc_found) state_next = SEND;
            SEND:    if (issue && last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        spike_ready = 1'b0;
        busy        = 1'b0;
        issue       = 1'b0;
        issue_vc    = '0;
        vc_onehot   = VIRTUAL_CHANNEL'(1) << vc_q;
        case (state)
            IDLE:  spike_ready = 1'b1;
            ALLOC: busy = 1'b1;
            SEND: begin
                busy  = 1'b1;
                issue = (credit_cnt[vc_q] != '0);
            end
            default: ;
        endcase
        // Flit index 0 is the head; payload words are consumed from the low end of the shifter
        if (idx == '0) begin
            flit_type = TYPE_HEAD;
            flit_data = 32'({src_x, src_y, dx_q, dy_q});
        end else begin
            flit_type = last ? TYPE_TAIL : TYPE_BODY;
            flit_data = spikes[31:0];
        end
        flit_next = FLIT_WIDTH'({flit_type, vc_onehot, flit_data});
        if (issue) issue_vc = vc_onehot;
    end

    always_ff @(posedge router_clk) begin
        if (router_rst) begin
            spikes <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            vc_q   <= '0;
            idx    <= '0;
        end else begin
            if (load) begin
                spikes <= spike_in;
                dx_q   <= dest_x;
                dy_q   <= dest_y;
            end
            if (state == ALLOC && vc_found) begin
                vc_q <= vc_sel;
                idx  <= '0;
            end
            if (issue) begin
                idx <= idx + IDX_W'(1);
                if (idx != '0) spikes <= spikes >> 32;
            end
        end
    end

    // Issue and credit return on the same VC cancel; returns saturate at the buffer depth
    always_ff @(posedge router_clk) begin
        if (router_rst) begin
            for (int v = 0; v < int'(VIRTUAL_CHANNEL); v++) credit_cnt[v] <= CNT_W'(BUFFER_DEPTH);
        end else begin
            for (int v = 0; v < int'(VIRTUAL_CHANNEL); v++) begin
                if (issue_vc[v] && !credit_in[v])
                    credit_cnt[v] <= credit_cnt[v] - CNT_W'(1);
                else if (credit_in[v] && !issue_vc[v] && credit_cnt[v] < CNT_W'(BUFFER_DEPTH))
                    credit_cnt[v] <= credit_cnt[v] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge router_clk) begin
        if (router_rst) begin
            flit_out_wr <= 1'b0;
            flit_out    <= '0;
        end else begin
            flit_out_wr <= issue;
            flit_out    <= issue ? flit_next : '0;
        end
    end

endmodule

// File: tb/tb_ni_spike_tx.sv
// Bench for ni_spike_tx: queue-based packet/credit model compared every cycle, plus literal spot checks.
module tb_ni_spike_tx;
    localparam int VC    = 4;
    localparam int AW    = 5;
    localparam int FW    = 38;
    localparam int NN    = 128;
    localparam int DEPTH = 8;
    localparam int P     = NN / 32;
`ifdef NI_TX_EMPTY_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          spike_valid;
    logic [NN-1:0] spike_in;
    logic [AW-1:0] src_x, src_y, dest_x, dest_y;
    logic          spike_ready;
    logic [VC-1:0] credit_in;
    logic          flit_out_wr;
    logic [FW-1:0] flit_out;
    logic          busy;

    ni_spike_tx dut (
        .router_clk (clk),
        .router_rst (rst),
        .spike_valid(spike_valid),
        .spike_in   (spike_in),
        .src_x      (src_x),
        .src_y      (src_y),
        .dest_x     (dest_x),
        .dest_y     (dest_y),
        .spike_ready(spike_ready),
        .credit_in  (credit_in),
        .flit_out_wr(flit_out_wr),
        .flit_out   (flit_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a packet is a queue of {type,data}; VC is chosen one cycle after acceptance
    logic [33:0]   pkt[$];
    int            m_cred[VC];
    int            m_vc;
    logic          m_wr;
    logic [FW-1:0] m_flit;

    always @(posedge clk) begin : model
        int         issue_v;
        logic [33:0] f;
        logic [3:0]  oh;
        issue_v = -1;
        if (rst) begin
            pkt.delete();
            m_vc   = -1;
            m_wr   = 1'b0;
            m_flit = '0;
            for (int v = 0; v < VC; v++) m_cred[v] = DEPTH;
        end else begin
            m_wr   = 1'b0;
            m_flit = '0;
            if (pkt.size() == 0) begin
                if (spike_valid && (!DROP || spike_in != '0)) begin
                    pkt.push_back({2'b10, 12'h000, src_x, src_y, dest_x, dest_y});
                    for (int k = 0; k < P; k++)
                        pkt.push_back({(k == P - 1) ? 2'b01 : 2'b00, spike_in[32*k +: 32]});
                    m_vc = -1;
                end
            end else if (m_vc < 0) begin
                for (int v = VC - 1; v >= 0; v--) if (m_cred[v] > 0) m_vc = v;
            end else if (m_cred[m_vc] > 0) begin
                f       = pkt.pop_front();
                oh      = 4'b0001 << m_vc;
                m_flit  = {f[33:32], oh, f[31:0]};
                m_wr    = 1'b1;
                issue_v = m_vc;
            end
            for (int v = 0; v < VC; v++) begin
                if (v == issue_v && !credit_in[v]) m_cred[v] = m_cred[v] - 1;
                else if (credit_in[v] && v != issue_v && m_cred[v] < DEPTH) m_cred[v] = m_cred[v] + 1;
            end
        end
    end

    // Per-cycle compare and flit capture
    logic [FW-1:0] cap_f[$];
    int            cap_c[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        check("spike_ready", {63'b0, spike_ready}, {63'b0, pkt.size() == 0});
        check("busy", {63'b0, busy}, {63'b0, pkt.size() != 0});
        check("flit_out_wr", {63'b0, flit_out_wr}, {63'b0, m_wr});
        check("flit_out", 64'(flit_out), 64'(m_flit));
        if (flit_out_wr) begin
            cap_f.push_back(flit_out);
            cap_c.push_back(cyc);
        end
    end

    task automatic send(input logic [NN-1:0] v, input logic [AW-1:0] dx, input logic [AW-1:0] dy);
        spike_valid = 1'b1;
        spike_in    = v;
        dest_x      = dx;
        dest_y      = dy;
        @(negedge clk);
        acc_cyc     = cyc;
        spike_valid = 1'b0;
    endtask

    task automatic credit(input int v);
        credit_in    = '0;
        credit_in[v] = 1'b1;
        @(negedge clk);
        credit_in = '0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && !spike_ready; i++) @(negedge clk);
        check("idle_reached", {63'b0, spike_ready}, 64'd1);
    endtask

    task automatic wait_caps(input int n, input int max);
        for (int i = 0; i < max && cap_f.size() < n; i++) @(negedge clk);
        check("flits_reached", {63'b0, cap_f.size() >= n}, 64'd1);
    endtask

    task automatic clear_caps();
        cap_f.delete();
        cap_c.delete();
    endtask

    initial begin
        rst = 1'b1; spike_valid = 1'b0; spike_in = '0; credit_in = '0;
        src_x = 5'd1; src_y = 5'd1; dest_x = '0; dest_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {63'b0, spike_ready}, 64'd1);
        check("rst_wr", {63'b0, flit_out_wr}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);

        // Basic packet on VC0, full credits
        clear_caps();
        send(128'h1, 5'd3, 5'd2);
        wait_idle(40);
        check("p1_count", 64'(cap_f.size()), 64'd5);
        if (cap_f.size() == 5) begin
            check("p1_head", 64'(cap_f[0]), 64'h21_0000_8462);
            check("p1_body0", 64'(cap_f[1]), 64'h01_0000_0001);
            check("p1_tail", 64'(cap_f[4]), 64'h11_0000_0000);
            check("p1_head_lat", 64'(cap_c[0] - acc_cyc), 64'd2);
            check("p1_tail_lat", 64'(cap_c[4] - acc_cyc), 64'd6);
        end
        check("p1_cred0", 64'(m_cred[0]), 64'd3);

        // VC0 runs dry mid-packet, then single credits release one flit each
        clear_caps();
        send(128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 5'd7, 5'd9);
        wait_caps(3, 40);
        repeat (4) @(negedge clk);
        check("p2_stall", 64'(cap_f.size()), 64'd3);
        credit(0);
        repeat (4) @(negedge clk);
        check("p2_one_more", 64'(cap_f.size()), 64'd4);
        credit(0);
        wait_idle(40);
        check("p2_count", 64'(cap_f.size()), 64'd5);
        if (cap_f.size() == 5) begin
            check("p2_body0", 64'(cap_f[1]), 64'h01_FEDC_BA98);
            check("p2_tail", 64'(cap_f[4]), 64'h11_DEAD_BEEF);
        end
        check("p2_cred0", 64'(m_cred[0]), 64'd0);

        // VC0 empty -> VC1 chosen
        clear_caps();
        send({4{32'h5555AAAA}}, 5'd0, 5'd31);
        wait_idle(40);
        check("p3_count", 64'(cap_f.size()), 64'd5);
        foreach (cap_f[i]) check("p3_vc_field", 64'(cap_f[i][35:32]), 64'b0010);
        check("p3_cred1", 64'(m_cred[1]), 64'd3);

        // VC1 stall, single release, then issue with same-cycle credit
        clear_caps();
        send({32'h4, 32'h3, 32'h2, 32'h1}, 5'd4, 5'd5);
        wait_caps(3, 40);
        repeat (4) @(negedge clk);
        check("p4_stall", 64'(cap_f.size()), 64'd3);
        credit(1);
        repeat (4) @(negedge clk);
        check("p4_one_more", 64'(cap_f.size()), 64'd4);
        credit_in = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        credit_in = '0;
        wait_idle(40);
        check("p4_count", 64'(cap_f.size()), 64'd5);
        check("p4_cred1_same_cycle", 64'(m_cred[1]), 64'd1);

        // Reset with credits ignored, then saturation at the reset value
        rst = 1'b1;
        credit_in = '1;
        repeat (2) @(negedge clk);
        credit_in = '0;
        rst = 1'b0;
        credit_in = '1;
        repeat (9) @(negedge clk);
        credit_in = '0;
        check("sat_cred0", 64'(m_cred[0]), 64'd8);
        clear_caps();
        send(128'hF0, 5'd2, 5'd2);
        wait_idle(40);
        clear_caps();
        send(128'h0F, 5'd2, 5'd2);
        wait_caps(3, 40);
        repeat (4) @(negedge clk);
        check("sat_stall", 64'(cap_f.size()), 64'd3);
        credit(0);
        @(negedge clk);
        credit(0);
        wait_idle(40);
        check("sat_count", 64'(cap_f.size()), 64'd5);

        // Reset after the second flit aborts the packet
        clear_caps();
        send(128'hABCD, 5'd6, 5'd6);
        wait_caps(2, 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {63'b0, spike_ready}, 64'd1);
        repeat (6) @(negedge clk);
        check("abort_count", 64'(cap_f.size()), 64'd2);
        for (int v = 0; v < VC; v++) check("abort_cred", 64'(m_cred[v]), 64'd8);

        // All-zero vector
        clear_caps();
        send('0, 5'd1, 5'd2);
        wait_idle(40);
        repeat (3) @(negedge clk);
        check("zero_count", 64'(cap_f.size()), DROP ? 64'd0 : 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
